cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Transmit end of the common data bus. Buffers completed results from NUM_FU
//  execution units and drives up to CDB_W broadcasts per cycle. Consumers are the
//  reservation stations, ROB and PRF. Per-FU FIFOs plus a round-robin arbiter.
//  All CDB outputs are registered, so consumers see a clean, glitch-free bus.
// PARAMETERS
//  NUM_FU      4   execution units feeding the bus
//  CDB_W       2   broadcast slots per cycle (CDB_W <= NUM_FU)
//  PHYS_W      6   physical register tag width
//  ROB_W       6   ROB tag width
//  FIFO_DEPTH  2   result buffer entries per FU (power of 2, >=1)
// PORTS
//  clk           in   1                  clock
//  reset         in   1                  synchronous, active-low reset
//  flush         in   1                  squash all buffered and pending results
//  fu_valid      in   [NUM_FU]           FU result valid
//  fu_ready      out  [NUM_FU]           FIFO can accept a result
//  fu_tag        in   [NUM_FU][PHYS_W]   destination physical tag
//  fu_value      in   [NUM_FU][64]       result value
//  fu_rob_tag    in   [NUM_FU][ROB_W]    ROB entry of the result
//  cdb_valid     out  [CDB_W]            broadcast slot valid
//  cdb_tag       out  [CDB_W][PHYS_W]    broadcast physical tag
//  cdb_value     out  [CDB_W][64]        broadcast value
//  cdb_rob_tag   out  [CDB_W][ROB_W]     broadcast ROB tag
//  stall_cnt     out  16                 saturating count of cycles with an unserved FIFO
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - All FIFOs are emptied. rr_ptr=0. cdb_* outputs = 0. stall_cnt = 0.
//   - fu_ready reads 1 in the first cycle after reset.
//  Push:
//   - fu_ready[f] = (count[f] < FIFO_DEPTH). It depends on registered state only.
//     A pop in the same cycle does not raise it.
//   - At a posedge with fu_valid[f] && fu_ready[f], {tag,value,rob_tag} is written
//     at the FIFO tail.
//   - fu_valid while !fu_ready is ignored. The FU must hold the result.
//  Arbitration (combinational on registered FIFO state, every cycle):
//   - Scan FUs in order rr_ptr, rr_ptr+1, ... (mod NUM_FU).
//   - The first CDB_W non-empty FIFOs are granted, one grant max per FU per cycle.
//   - The k-th grant in scan order takes slot k. Unused slots are invalid.
//   - rr_ptr <= (last granted FU + 1) mod NUM_FU. With no grant, rr_ptr holds.
//  Pop / broadcast:
//   - Granted FIFO heads are popped at the posedge.
//   - Their fields load into cdb_* registers at that same posedge.
//   - cdb_valid[k] = 1 for exactly one cycle per granted result.
//  Latency:
//   - A result accepted at posedge N into an empty FIFO is granted in cycle N..N+1.
//   - It appears on the CDB after posedge N+1 (2 edges) if it wins arbitration.
//   - No bypass from fu_* to cdb_*.
//   - Per-FU order is preserved. Cross-FU order is by arbitration only.
//  Simultaneous push and pop on one FIFO:
//   - Both take effect. Count is unchanged. Pointers wrap mod FIFO_DEPTH.
//  flush (synchronous, active-high):
//   - At the posedge, all FIFOs are emptied and pushes in that cycle are dropped.
//   - cdb_valid <= 0 and rr_ptr <= 0. stall_cnt holds.
//   - Results granted in the flush cycle are not broadcast.
//  stall_cnt:
//   - Increments when at least one non-empty FIFO is not granted in a cycle.
//   - Saturates at 16'hFFFF.
//  Reset takes priority over flush.
//   - Reset mid-stream discards all buffered results with no broadcast.
//  Tags are not checked. Duplicate tags are broadcast as supplied.
// TESTING
//  1. Single result:
//     - Stimulus: FU1 pushes tag=6'h05, value=64'hDEAD, rob=3 at edge 0.
//     - Response: cdb_valid=2'b01 after edge 1 with slot0={5,DEAD,3}. Next cycle cdb_valid=0.
//  2. Contention:
//     - Stimulus: FU0..3 push together with rr_ptr=0.
//     - Response: first beat slots={FU0,FU1}, second beat {FU2,FU3}, rr_ptr ends at 0.
//       stall_cnt += 1.
//  3. Backpressure:
//     - Stimulus: FU2 pushes 3 results back-to-back and FU0, FU1 are kept full.
//     - Response: fu_ready[2]=0 once count=2.
//       FU2's results are broadcast in push order with none lost.
//  4. Fairness:
//     - Stimulus: FU0 and FU1 streaming continuously, then FU3 starts pushing.
//     - Response: FU3 is granted within 2 cycles of becoming non-empty.
//  5. Flush:
//     - Stimulus: all FIFOs full, then flush=1 for 1 cycle.
//     - Response: after the edge, cdb_valid=0, all fu_ready=1, no stale broadcast in
//       later cycles.
//  6. Reset:
//     - Stimulus: reset=0 mid-stream with 4 buffered results.
//     - Response: all outputs 0, stall_cnt=0, and no buffered result broadcast after
//       reset=1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus transmit end: per-FU result FIFOs drained by a round-robin
// arbiter into CDB_W registered broadcast slots.
module cdb_arbiter #(
   parameter int NUM_FU     = 4,
   parameter int CDB_W      = 2,
   parameter int PHYS_W     = 6,
   parameter int ROB_W      = 6,
   parameter int FIFO_DEPTH = 2,
   parameter int DATA_W     = 64
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_flush,
   input  logic [NUM_FU-1:0]          i_fu_valid,
   output logic [NUM_FU-1:0]          o_fu_ready,
   input  logic [NUM_FU*PHYS_W-1:0]   i_fu_tag,
   input  logic [NUM_FU*DATA_W-1:0]   i_fu_value,
   input  logic [NUM_FU*ROB_W-1:0]    i_fu_rob_tag,
   output logic [CDB_W-1:0]           o_cdb_valid,
   output logic [CDB_W*PHYS_W-1:0]    o_cdb_tag,
   output logic [CDB_W*DATA_W-1:0]    o_cdb_value,
   output logic [CDB_W*ROB_W-1:0]     o_cdb_rob_tag,
   output logic [15:0]                o_stall_cnt
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int SLOT_W = (CDB_W > 1) ? $clog2(CDB_W) : 1;
   localparam int ENT_W  = PHYS_W + DATA_W + ROB_W;

   logic [ENT_W-1:0] r_mem     [NUM_FU][FIFO_DEPTH];
   logic [PTR_W-1:0] r_rd_ptr  [NUM_FU];
   logic [PTR_W-1:0] r_wr_ptr  [NUM_FU];
   logic [CNT_W-1:0] r_cnt     [NUM_FU];
   logic [FU_W-1:0]  r_rr_ptr;
   logic [15:0]      r_stall_cnt;

   logic [CDB_W-1:0] r_cdb_vld_p1;
   logic [ENT_W-1:0] r_cdb_ent_p1 [CDB_W];

   logic [NUM_FU-1:0] w_nonempty;
   logic [NUM_FU-1:0] w_push;
   logic [NUM_FU-1:0] w_grant;
   logic [CDB_W-1:0]  w_slot_vld;
   logic [FU_W-1:0]   w_slot_fu  [CDB_W];
   logic [ENT_W-1:0]  w_slot_ent [CDB_W];
   logic [FU_W-1:0]   w_rr_next;
   logic              w_stall;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) return v;
      return v + 16'd1;
   endfunction

   // Stage p0: FIFO occupancy, push qualification and arbitration on registered state
   always_comb begin
      for (int f = 0; f < NUM_FU; f++) begin
         w_nonempty[f] = (r_cnt[f] != '0);
         o_fu_ready[f] = (r_cnt[f] < CNT_W'(FIFO_DEPTH));
         w_push[f]     = i_fu_valid[f] & o_fu_ready[f] & ~i_flush;
      end
   end

   always_comb begin
      int idx;
      int n_gnt;
      idx        = 0;
      n_gnt      = 0;
      w_grant    = '0;
      w_slot_vld = '0;
      w_rr_next  = r_rr_ptr;
      w_stall    = 1'b0;
      for (int k = 0; k < CDB_W; k++) w_slot_fu[k] = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         idx = int'(r_rr_ptr) + i;
         if (idx >= NUM_FU) idx = idx - NUM_FU;
         if (w_nonempty[idx[FU_W-1:0]]) begin
            if (n_gnt < CDB_W) begin
               w_grant[idx[FU_W-1:0]]      = 1'b1;
               w_slot_vld[n_gnt[SLOT_W-1:0]] = 1'b1;
               w_slot_fu[n_gnt[SLOT_W-1:0]]  = idx[FU_W-1:0];
               w_rr_next = (idx == NUM_FU - 1) ? '0 : FU_W'(idx + 1);
               n_gnt     = n_gnt + 1;
            end else begin
               w_stall = 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < CDB_W; k++)
         w_slot_ent[k] = r_mem[w_slot_fu[k]][r_rd_ptr[w_slot_fu[k]]];
   end

   // Stage p0 -> p1: FIFO state update, pop of granted heads, CDB load
   always_ff @(posedge i_clk) begin
      for (int f = 0; f < NUM_FU; f++) begin
         if (w_push[f])
            r_mem[f][r_wr_ptr[f]] <= {i_fu_tag[f*PHYS_W +: PHYS_W],
                                      i_fu_value[f*DATA_W +: DATA_W],
                                      i_fu_rob_tag[f*ROB_W +: ROB_W]};
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset || i_flush) begin
         for (int f = 0; f < NUM_FU; f++) begin
            r_rd_ptr[f] <= '0;
            r_wr_ptr[f] <= '0;
            r_cnt[f]    <= '0;
         end
      end else begin
         for (int f = 0; f < NUM_FU; f++) begin
            if (w_push[f])  r_wr_ptr[f] <= ptr_inc(r_wr_ptr[f]);
            if (w_grant[f]) r_rd_ptr[f] <= ptr_inc(r_rd_ptr[f]);
            r_cnt[f] <= r_cnt[f] + CNT_W'(w_push[f]) - CNT_W'(w_grant[f]);
         end
      end
   end

   // Flush squashes this cycle's grants but keeps the stall history
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_cdb_vld_p1 <= '0;
         r_rr_ptr     <= '0;
         r_stall_cnt  <= '0;
         for (int k = 0; k < CDB_W; k++) r_cdb_ent_p1[k] <= '0;
      end else if (i_flush) begin
         r_cdb_vld_p1 <= '0;
         r_rr_ptr     <= '0;
      end else begin
         r_cdb_vld_p1 <= w_slot_vld;
         r_rr_ptr     <= w_rr_next;
         if (w_stall) r_stall_cnt <= sat_inc16(r_stall_cnt);
         for (int k = 0; k < CDB_W; k++)
            if (w_slot_vld[k]) r_cdb_ent_p1[k] <= w_slot_ent[k];
      end
   end

   // Stage p1: registered broadcast
   always_comb begin
      o_cdb_valid = r_cdb_vld_p1;
      o_stall_cnt = r_stall_cnt;
      for (int k = 0; k < CDB_W; k++) begin
         o_cdb_tag[k*PHYS_W +: PHYS_W]     = r_cdb_ent_p1[k][ENT_W-1 -: PHYS_W];
         o_cdb_value[k*DATA_W +: DATA_W]   = r_cdb_ent_p1[k][ROB_W +: DATA_W];
         o_cdb_rob_tag[k*ROB_W +: ROB_W]   = r_cdb_ent_p1[k][ROB_W-1:0];
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single result, contention, backpressure,
// fairness, flush and mid-stream reset with hand-computed CDB beats.
module tb_cdb_arbiter;
   localparam int NUM_FU = 4, CDB_W = 2, PHYS_W = 6, ROB_W = 6, FIFO_DEPTH = 2, DATA_W = 64;

   logic                     i_clk = 1'b0;
   logic                     i_reset;
   logic                     i_flush;
   logic [NUM_FU-1:0]        i_fu_valid;
   logic [NUM_FU-1:0]        o_fu_ready;
   logic [NUM_FU*PHYS_W-1:0] i_fu_tag;
   logic [NUM_FU*DATA_W-1:0] i_fu_value;
   logic [NUM_FU*ROB_W-1:0]  i_fu_rob_tag;
   logic [CDB_W-1:0]         o_cdb_valid;
   logic [CDB_W*PHYS_W-1:0]  o_cdb_tag;
   logic [CDB_W*DATA_W-1:0]  o_cdb_value;
   logic [CDB_W*ROB_W-1:0]   o_cdb_rob_tag;
   logic [15:0]              o_stall_cnt;

   int n_pass  = 0;
   int n_total = 0;
   int test_id = 0;

   cdb_arbiter #(
      .NUM_FU(NUM_FU), .CDB_W(CDB_W), .PHYS_W(PHYS_W), .ROB_W(ROB_W),
      .FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
      .i_fu_valid(i_fu_valid), .o_fu_ready(o_fu_ready),
      .i_fu_tag(i_fu_tag), .i_fu_value(i_fu_value), .i_fu_rob_tag(i_fu_rob_tag),
      .o_cdb_valid(o_cdb_valid), .o_cdb_tag(o_cdb_tag), .o_cdb_value(o_cdb_value),
      .o_cdb_rob_tag(o_cdb_rob_tag), .o_stall_cnt(o_stall_cnt)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [63:0] val_of(input logic [5:0] t);
      return 64'hFEED_0000_0000_0000 | (64'(test_id) << 8) | 64'(t);
   endfunction

   function automatic logic [5:0] rob_of(input logic [5:0] t);
      return t ^ 6'h15;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_fu(input int f, input logic [5:0] t);
      i_fu_valid[f]                    = 1'b1;
      i_fu_tag[f*PHYS_W +: PHYS_W]     = t;
      i_fu_value[f*DATA_W +: DATA_W]   = val_of(t);
      i_fu_rob_tag[f*ROB_W +: ROB_W]   = rob_of(t);
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", name, got, exp);
   endtask

   task automatic chk_slot(input string name, input int k, input logic [5:0] t);
      chk({name, ".tag"}, 64'(o_cdb_tag[k*PHYS_W +: PHYS_W]), 64'(t));
      chk({name, ".val"}, o_cdb_value[k*DATA_W +: DATA_W], val_of(t));
      chk({name, ".rob"}, 64'(o_cdb_rob_tag[k*ROB_W +: ROB_W]), 64'(rob_of(t)));
   endtask

   initial begin
      i_reset      = 1'b0;
      i_flush      = 1'b0;
      i_fu_valid   = '0;
      i_fu_tag     = '0;
      i_fu_value   = '0;
      i_fu_rob_tag = '0;
      tick();
      tick();
      i_reset = 1'b1;
      tick();
      chk("rst.ready", 64'(o_fu_ready), 64'hF);
      chk("rst.valid", 64'(o_cdb_valid), 64'h0);
      chk("rst.tag",   64'(o_cdb_tag), 64'h0);
      chk("rst.value", o_cdb_value[63:0], 64'h0);
      chk("rst.stall", 64'(o_stall_cnt), 64'h0);

      // single result from FU1
      test_id = 1;
      i_fu_valid[1] = 1'b1;
      i_fu_tag[1*PHYS_W +: PHYS_W]   = 6'h05;
      i_fu_value[1*DATA_W +: DATA_W] = 64'hDEAD;
      i_fu_rob_tag[1*ROB_W +: ROB_W] = 6'd3;
      tick();
      i_fu_valid = '0;
      chk("t1.nobypass", 64'(o_cdb_valid), 64'h0);
      tick();
      chk("t1.valid", 64'(o_cdb_valid), 64'h1);
      chk("t1.tag",   64'(o_cdb_tag[PHYS_W-1:0]), 64'h05);
      chk("t1.value", o_cdb_value[63:0], 64'hDEAD);
      chk("t1.rob",   64'(o_cdb_rob_tag[ROB_W-1:0]), 64'h3);
      tick();
      chk("t1.once", 64'(o_cdb_valid), 64'h0);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("t1.stall", 64'(o_stall_cnt), 64'h0);

      // contention: all four FUs push together with rr_ptr at 0
      test_id = 2;
      for (int f = 0; f < NUM_FU; f++) set_fu(f, 6'(f*16 + 1));
      tick();
      i_fu_valid = '0;
      chk("t2.ready", 64'(o_fu_ready), 64'hF);
      tick();
      chk("t2.b0.valid", 64'(o_cdb_valid), 64'h3);
      chk_slot("t2.b0.s0", 0, 6'h01);
      chk_slot("t2.b0.s1", 1, 6'h11);
      chk("t2.b0.stall", 64'(o_stall_cnt), 64'h1);
      tick();
      chk("t2.b1.valid", 64'(o_cdb_valid), 64'h3);
      chk_slot("t2.b1.s0", 0, 6'h21);
      chk_slot("t2.b1.s1", 1, 6'h31);
      chk("t2.b1.stall", 64'(o_stall_cnt), 64'h1);
      tick();
      chk("t2.idle", 64'(o_cdb_valid), 64'h0);
      // rr_ptr back at 0 puts FU0 ahead of FU3
      set_fu(0, 6'h02);
      set_fu(3, 6'h32);
      tick();
      i_fu_valid = '0;
      tick();
      chk("t2.rr.valid", 64'(o_cdb_valid), 64'h3);
      chk_slot("t2.rr.s0", 0, 6'h02);
      chk_slot("t2.rr.s1", 1, 6'h32);
      tick();
      chk("t2.rr.idle", 64'(o_cdb_valid), 64'h0);
      chk("t2.rr.stall", 64'(o_stall_cnt), 64'h1);

      // backpressure on FU2 while FU0/FU1 keep pushing
      test_id = 3;
      set_fu(0, 6'h03); set_fu(1, 6'h13); set_fu(2, 6'h23);
      tick();
      chk("t3.A.ready", 64'(o_fu_ready), 64'hF);
      set_fu(0, 6'h04); set_fu(1, 6'h14); set_fu(2, 6'h24);
      tick();
      chk("t3.B.valid", 64'(o_cdb_valid), 64'h3);
      chk_slot("t3.B.s0", 0, 6'h03);
      chk_slot("t3.B.s1", 1, 6'h13);
      chk("t3.B.ready", 64'(o_fu_ready), 64'hB);
      chk("t3.B.stall", 64'(o_stall_cnt), 64'h2);
      set_fu(0, 6'h05); set_fu(1, 6'h15); set_fu(2, 6'h25);
      tick();
      chk("t3.C.valid", 64'(o_cdb_valid), 64'h3);
      chk_slot("t3.C.s0", 0, 6'h23);
      chk_slot("t3.C.s1", 1, 6'h04);
      chk("t3.C.ready", 64'(o_fu_ready), 64'hD);
      chk("t3.C.stall", 64'(o_stall_cnt), 64'h3);
      i_fu_valid = 4'b0100;
      tick();
      i_fu_valid = '0;
      chk_slot("t3.D.s0", 0, 6'h14);
      chk_slot("t3.D.s1", 1, 6'h24);
      chk("t3.D.ready", 64'(o_fu_ready), 64'hF);
      chk("t3.D.stall", 64'(o_stall_cnt), 64'h4);
      tick();
      chk("t3.E.valid", 64'(o_cdb_valid), 64'h3);
      chk_slot("t3.E.s0", 0, 6'h05);
      chk_slot("t3.E.s1", 1, 6'h15);
      chk("t3.E.stall", 64'(o_stall_cnt), 64'h5);
      tick();
      chk("t3.F.valid", 64'(o_cdb_valid), 64'h1);
      chk_slot("t3.F.s0", 0, 6'h25);
      tick();
      chk("t3.idle", 64'(o_cdb_valid), 64'h0);

      // fairness: FU3 joins two streaming FUs
      test_id = 4;
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      set_fu(0, 6'h06); set_fu(1, 6'h16);
      tick();
      set_fu(0, 6'h07); set_fu(1, 6'h17); set_fu(3, 6'h36);
      tick();
      i_fu_valid = '0;
      chk("t4.P2.valid", 64'(o_cdb_valid), 64'h3);
      chk_slot("t4.P2.s0", 0, 6'h06);
      chk_slot("t4.P2.s1", 1, 6'h16);
      tick();
      chk("t4.P3.valid", 64'(o_cdb_valid), 64'h3);
      chk_slot("t4.P3.s0", 0, 6'h36);
      chk_slot("t4.P3.s1", 1, 6'h07);
      chk("t4.P3.stall", 64'(o_stall_cnt), 64'h6);
      tick();
      chk("t4.P4.valid", 64'(o_cdb_valid), 64'h1);
      chk_slot("t4.P4.s0", 0, 6'h17);
      tick();
      chk("t4.idle", 64'(o_cdb_valid), 64'h0);

      // flush with loaded FIFOs and pushes in the flush cycle
      test_id = 5;
      for (int f = 0; f < NUM_FU; f++) set_fu(f, 6'(f*16 + 8));
      tick();
      for (int f = 0; f < NUM_FU; f++) set_fu(f, 6'(f*16 + 9));
      tick();
      chk("t5.Q2.valid", 64'(o_cdb_valid), 64'h3);
      chk_slot("t5.Q2.s0", 0, 6'h28);
      chk_slot("t5.Q2.s1", 1, 6'h38);
      chk("t5.Q2.ready", 64'(o_fu_ready), 64'hC);
      chk("t5.Q2.stall", 64'(o_stall_cnt), 64'h7);
      i_flush = 1'b1;
      tick();
      i_flush    = 1'b0;
      i_fu_valid = '0;
      chk("t5.flush.valid", 64'(o_cdb_valid), 64'h0);
      chk("t5.flush.ready", 64'(o_fu_ready), 64'hF);
      chk("t5.flush.stall", 64'(o_stall_cnt), 64'h7);
      tick();
      chk("t5.post1.valid", 64'(o_cdb_valid), 64'h0);
      tick();
      chk("t5.post2.valid", 64'(o_cdb_valid), 64'h0);
      chk("t5.post2.stall", 64'(o_stall_cnt), 64'h7);

      // reset mid-stream with four buffered results
      test_id = 6;
      for (int f = 0; f < NUM_FU; f++) set_fu(f, 6'(f*16 + 10));
      tick();
      i_fu_valid = '0;
      chk("t6.ready", 64'(o_fu_ready), 64'hF);
      i_reset = 1'b0;
      tick();
      chk("t6.rst.valid", 64'(o_cdb_valid), 64'h0);
      chk("t6.rst.tag",   64'(o_cdb_tag), 64'h0);
      chk("t6.rst.value", o_cdb_value[63:0], 64'h0);
      chk("t6.rst.rob",   64'(o_cdb_rob_tag), 64'h0);
      chk("t6.rst.stall", 64'(o_stall_cnt), 64'h0);
      chk("t6.rst.ready", 64'(o_fu_ready), 64'hF);
      i_reset = 1'b1;
      tick();
      chk("t6.post1.valid", 64'(o_cdb_valid), 64'h0);
      tick();
      chk("t6.post2.valid", 64'(o_cdb_valid), 64'h0);
      chk("t6.post2.stall", 64'(o_stall_cnt), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
